// File: rtl/edge_arb_pkg.sv
// Shared constants for the edge event arbiter: channel mode encodings and
// the event polarity values presented on ev_pol.
package edge_arb_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam logic EV_POL_RISE = 1'b1;
  localparam logic EV_POL_FALL = 1'b0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting index found
// when searching upward from ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int CH_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic            gnt_valid,
  output logic [CH_W-1:0] gnt_idx
);

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt_valid = 1'b1;
        gnt_idx   = CH_W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with pending-event bits, sticky overflow flags and
// a round-robin fed single-entry valid/ready event port.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter  int         N_CH     = 4,
  parameter  logic [1:0] RST_MODE = MODE_BOTH,
  localparam int         CH_W     = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sig_in,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [1:0]      cfg_mode,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CH_W-1:0] ev_ch,
  output logic            ev_pol,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  logic [N_CH-1:0]      prev, pend_r, pend_f, pend_any;
  logic [N_CH-1:0]      rise, fall, gnt_r, gnt_f, ovf_set;
  logic [N_CH-1:0]      pend_r_nxt, pend_f_nxt;
  logic [N_CH-1:0][1:0] mode;
  logic                 prime, free, grant, gnt_valid;
  logic [CH_W-1:0]      ptr, gnt_idx;

  assign pend_any = pend_r | pend_f;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req       (pend_any),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A config write clears disabled pending types after any edge has set them.
  always_comb begin
    free       = ~ev_valid | ev_ready;
    grant      = free & gnt_valid;
    rise       = '0;
    fall       = '0;
    gnt_r      = '0;
    gnt_f      = '0;
    ovf_set    = '0;
    pend_r_nxt = '0;
    pend_f_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      rise[i]    = ~prime & sig_in[i] & ~prev[i] & mode[i][0];
      fall[i]    = ~prime & ~(sig_in[i] | ~prev[i]) & mode[i][1];
      gnt_r[i]   = grant & (gnt_idx == CH_W'(i)) & pend_r[i];
      gnt_f[i]   = grant & (gnt_idx == CH_W'(i)) & ~pend_r[i];
      ovf_set[i] = (rise[i] & pend_r[i] & ~gnt_r[i]) |
                   (fall[i] & pend_f[i] & ~gnt_f[i]);
      pend_r_nxt[i] = rise[i] | (pend_r[i] & ~gnt_r[i]);
      pend_f_nxt[i] = fall[i] | (pend_f[i] & ~gnt_f[i]);
      if (cfg_we && cfg_ch == CH_W'(i)) begin
        if (!cfg_mode[0]) pend_r_nxt[i] = 1'b0;
        if (!cfg_mode[1]) pend_f_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid <= 1'b0;
      ev_ch    <= '0;
      ev_pol   <= 1'b0;
      ovf      <= '0;
      pend_r   <= '0;
      pend_f   <= '0;
      prev     <= '0;
      prime    <= 1'b1;
      mode     <= {N_CH{RST_MODE}};
      ptr      <= '0;
    end else begin
      prime  <= 1'b0;
      prev   <= sig_in;
      pend_r <= pend_r_nxt;
      pend_f <= pend_f_nxt;
      ovf    <= ovf_set | (ovf & ~{N_CH{ovf_clr}});
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_we && cfg_ch == CH_W'(i)) mode[i] <= cfg_mode;
      end
      if (grant) begin
        ev_valid <= 1'b1;
        ev_ch    <= gnt_idx;
        ev_pol   <= (|gnt_r) ? EV_POL_RISE : EV_POL_FALL;
        ptr      <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
      end else if (free) begin
        ev_valid <= 1'b0;
      end
    end
  end

endmodule
